captura_clave_teclado: RTL and testbench
========================================

// Module: captura_clave_teclado
// PURPOSE
//   Upstream stage of the parking access controller. Collects PIN digits from
//   the keypad scanner and assembles the 16-bit BCD clave_ingresada that the
//   controller checks. Emits a one-cycle clave_valida strobe on ENTER. Enforces
//   digit count, inactivity timeout, and lockout while the bloqueo alarm is active.
// PARAMETERS
//   NUM_DIGITOS     4       digits per PIN; clave width = 4*NUM_DIGITOS (16)
//   TIMEOUT_CICLOS  5000    idle clocks after the last accepted key before the buffer is discarded
//   ANCHO_TIMEOUT   13      width of the timeout counter; must satisfy 2**W > TIMEOUT_CICLOS
// PORTS
//   clock                    in   1   system clock, rising edge
//   reset                    in   1   asynchronous reset, active-low
//   sensor_llegada_vehiculo  in   1   vehicle present at the gate; 1 enables capture
//   bloqueo                  in   1   driven from the controller's senal_alarma_bloqueo; 1 freezes the keypad
//   tecla_valida             in   1   key-held level from the scanner; may stay high many cycles
//   tecla_codigo             in   4   0x0-0x9 digit, 0xA BORRAR, 0xB ENTER, 0xC-0xF ignored
//   clave_ingresada          out  16  last submitted PIN, BCD, first digit in [15:12]
//   clave_valida             out  1   one-cycle strobe: clave_ingresada has just been updated
//   digitos_ingresados       out  3   digits currently buffered, 0..NUM_DIGITOS (display use)
//   error_formato            out  1   one-cycle strobe: ENTER pressed with fewer than NUM_DIGITOS digits
//   error_timeout            out  1   one-cycle strobe: buffer discarded because of inactivity
// BEHAVIOUR
//   Reset (reset==0, asynchronous): state=INACTIVO; buffer=0; count=0; timer=0;
//     tecla_prev=0; all outputs 0 (clave_ingresada=16'h0000).
//   Key event: tecla_valida==1 && tecla_prev==1'b0 at a rising clock edge. tecla_prev is
//     registered every cycle, so each physical press produces exactly one event.
//   FSM states:
//     INACTIVO - entered when sensor_llegada_vehiculo==0 or bloqueo==1; clears buffer, count, timer
//     ESPERA   - enabled, count==0
//     CAPTURA  - 0 < count < NUM_DIGITOS
//     COMPLETO - count==NUM_DIGITOS, waiting for ENTER
//   Priority at each edge: reset > (llegada==0 || bloqueo==1) -> INACTIVO > timeout > key event.
//     A key in the same cycle as disable is dropped.
//   INACTIVO -> ESPERA when llegada==1 && bloqueo==0. Keys are ignored during this cycle.
//   Digit key:
//     ESPERA/CAPTURA: buffer <= {buffer[11:0], digit}; count+1.
//     COMPLETO: ignored (no overwrite, no strobe).
//   BORRAR: buffer=0, count=0, next state ESPERA. No strobe.
//   ENTER:
//     count==NUM_DIGITOS: clave_ingresada<=buffer; clave_valida=1 for one cycle;
//       buffer and count cleared; next state ESPERA.
//     count<NUM_DIGITOS (including 0): error_formato=1 for one cycle; buffer cleared;
//       clave_ingresada unchanged.
//   Codes 0xC-0xF: ignored entirely; they do not restart the timer.
//   Timer:
//     Cleared on every accepted digit, BORRAR, or ENTER. Increments in CAPTURA and COMPLETO.
//     Held at 0 in INACTIVO and ESPERA.
//     When timer == TIMEOUT_CICLOS-1: error_timeout=1 for one cycle; buffer and count cleared;
//       next state ESPERA. A key event on the timeout cycle is discarded.
//   Latency: outputs are registered. A strobe is high during the cycle after the edge
//     that sampled the triggering key. clave_ingresada holds its value until the next
//     valid submission, and is unaffected by disable or reset-free state changes.
//   At most one of clave_valida, error_formato, error_timeout is high in any cycle.
// STRUCTURE
//   Shared header parking_defs.vh: key codes TECLA_BORRAR=4'hA, TECLA_ENTER=4'hB;
//     FSM state encodings (2 bits); PIN width constant shared with the access controller.
//   Sub-module detector_flanco: registered rising-edge detector (clock, reset, in, pulso).
//   One instance on tecla_valida.
//   Remaining logic: FSM, shift buffer, digit counter, timeout counter.
// TESTING
//   1. llegada=1, keys 1,2,3,4, then ENTER -> clave_ingresada=16'h1234, clave_valida for 1 cycle,
//      digitos_ingresados back to 0.
//   2. Keys 5,6 then ENTER -> error_formato pulse; clave_ingresada stays at its prior value;
//      digitos_ingresados=0.
//   3. Keys 9,8,7,6,5 then ENTER -> fifth digit ignored; clave_ingresada=16'h9876.
//   4. Key 4, then idle for TIMEOUT_CICLOS cycles -> single error_timeout pulse; count=0;
//      a following 1,1,1,1,ENTER yields 16'h1111.
//   5. Key 3 held high for 50 cycles -> counted once. BORRAR mid-entry -> buffer 0.
//      Codes 0xC-0xF have no effect.
//   6. Mid-entry bloqueo=1, or llegada=0, or async reset pulse -> state INACTIVO, buffer dropped,
//      no strobes. Reset additionally forces clave_ingresada=16'h0000.

Source files
------------

// File: rtl/captura_clave_teclado_pkg.sv
// Shared definitions for the PIN capture stage: key codes and FSM state encoding.
package captura_clave_teclado_pkg;

    localparam logic [3:0] TECLA_BORRAR = 4'hA;
    localparam logic [3:0] TECLA_ENTER  = 4'hB;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        ESPERA   = 2'd1,
        CAPTURA  = 2'd2,
        COMPLETO = 2'd3
    } estado_t;

    function automatic logic es_digito(input logic [3:0] codigo);
        return codigo <= 4'd9;
    endfunction

endpackage

// File: rtl/captura_clave_teclado_detector_flanco.sv
// Rising-edge detector: one pulse per low-to-high transition of a held level.
module detector_flanco (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulso
);

    logic prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) prev_q <= 1'b0;
        else        prev_q <= in;
    end

    assign pulso = in & ~prev_q;

endmodule

// File: rtl/captura_clave_teclado.sv
// Keypad PIN capture: buffers BCD digits, submits on ENTER, drops the entry on
// inactivity, disable or bloqueo.
module captura_clave_teclado
    import captura_clave_teclado_pkg::*;
#(
    parameter int NUM_DIGITOS    = 4,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int ANCHO_TIMEOUT  = 13
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               sensor_llegada_vehiculo,
    input  logic                               bloqueo,
    input  logic                               tecla_valida,
    input  logic [3:0]                         tecla_codigo,
    output logic [4*NUM_DIGITOS-1:0]           clave_ingresada,
    output logic                               clave_valida,
    output logic [$clog2(NUM_DIGITOS+1)-1:0]   digitos_ingresados,
    output logic                               error_formato,
    output logic                               error_timeout
);

    localparam int ANCHO_BUF = 4 * NUM_DIGITOS;
    localparam int ANCHO_CNT = $clog2(NUM_DIGITOS + 1);
    localparam logic [ANCHO_CNT-1:0]     CNT_MAX   = ANCHO_CNT'(NUM_DIGITOS);
    localparam logic [ANCHO_TIMEOUT-1:0] TIMER_FIN = ANCHO_TIMEOUT'(TIMEOUT_CICLOS - 1);

    estado_t                  estado_q, estado_d;
    logic [ANCHO_BUF-1:0]     buffer_q, buffer_d;
    logic [ANCHO_BUF-1:0]     clave_q, clave_d;
    logic [ANCHO_CNT-1:0]     cnt_q, cnt_d;
    logic [ANCHO_TIMEOUT-1:0] timer_q, timer_d;
    logic                     valida_q, valida_d;
    logic                     fmt_q, fmt_d;
    logic                     to_q, to_d;
    logic                     evento;

    detector_flanco u_flanco (
        .clock (clock),
        .reset (reset),
        .in    (tecla_valida),
        .pulso (evento)
    );

    always_comb begin
        estado_d = estado_q;
        buffer_d = buffer_q;
        clave_d  = clave_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        valida_d = 1'b0;
        fmt_d    = 1'b0;
        to_d     = 1'b0;

        if (!sensor_llegada_vehiculo || bloqueo) begin
            estado_d = INACTIVO;
            buffer_d = '0;
            cnt_d    = '0;
            timer_d  = '0;
        end else if (estado_q == INACTIVO) begin
            // Keys arriving on the enabling cycle are dropped.
            estado_d = ESPERA;
        end else if (estado_q != ESPERA && timer_q == TIMER_FIN) begin
            to_d     = 1'b1;
            buffer_d = '0;
            cnt_d    = '0;
            timer_d  = '0;
            estado_d = ESPERA;
        end else begin
            if (estado_q != ESPERA) timer_d = timer_q + 1'b1;
            if (evento) begin
                if (es_digito(tecla_codigo)) begin
                    if (cnt_q != CNT_MAX) begin
                        buffer_d = {buffer_q[ANCHO_BUF-5:0], tecla_codigo};
                        cnt_d    = cnt_q + 1'b1;
                        timer_d  = '0;
                        estado_d = (cnt_d == CNT_MAX) ? COMPLETO : CAPTURA;
                    end
                end else if (tecla_codigo == TECLA_BORRAR) begin
                    buffer_d = '0;
                    cnt_d    = '0;
                    timer_d  = '0;
                    estado_d = ESPERA;
                end else if (tecla_codigo == TECLA_ENTER) begin
                    if (cnt_q == CNT_MAX) begin
                        clave_d  = buffer_q;
                        valida_d = 1'b1;
                    end else begin
                        fmt_d = 1'b1;
                    end
                    buffer_d = '0;
                    cnt_d    = '0;
                    timer_d  = '0;
                    estado_d = ESPERA;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INACTIVO;
            buffer_q <= '0;
            clave_q  <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            valida_q <= 1'b0;
            fmt_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            estado_q <= estado_d;
            buffer_q <= buffer_d;
            clave_q  <= clave_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            valida_q <= valida_d;
            fmt_q    <= fmt_d;
            to_q     <= to_d;
        end
    end

    assign clave_ingresada    = clave_q;
    assign clave_valida       = valida_q;
    assign digitos_ingresados = cnt_q;
    assign error_formato      = fmt_q;
    assign error_timeout      = to_q;

endmodule

// File: tb/tb_captura_clave_teclado.sv
// Bench for captura_clave_teclado: queue-based reference model checked every cycle.
module tb_captura_clave_teclado;

    localparam int N  = 4;
    localparam int TO = 5000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        llegada = 1'b0;
    logic        bloqueo = 1'b0;
    logic        tecla_valida = 1'b0;
    logic [3:0]  tecla_codigo = 4'h0;
    logic [15:0] clave_ingresada;
    logic        clave_valida;
    logic [2:0]  digitos_ingresados;
    logic        error_formato;
    logic        error_timeout;

    int tests = 0;
    int fails = 0;
    int n_val = 0, n_fmt = 0, n_to = 0;
    bit chk_en = 1'b0;

    captura_clave_teclado dut (
        .clock                   (clock),
        .reset                   (reset),
        .sensor_llegada_vehiculo (llegada),
        .bloqueo                 (bloqueo),
        .tecla_valida            (tecla_valida),
        .tecla_codigo            (tecla_codigo),
        .clave_ingresada         (clave_ingresada),
        .clave_valida            (clave_valida),
        .digitos_ingresados      (digitos_ingresados),
        .error_formato           (error_formato),
        .error_timeout           (error_timeout)
    );

    always #5 clock = ~clock;

    // Reference model: digits in a queue, idle cycles since the last accepted key.
    logic [3:0]  digs[$];
    bit          m_en = 1'b0;
    bit          m_prev = 1'b0;
    int          idle = 0;
    logic [15:0] m_clave = 16'h0;
    bit          m_val = 1'b0, m_fmt = 1'b0, m_to = 1'b0;
    bit          ev, used;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            digs.delete(); m_en = 0; m_prev = 0; idle = 0; m_clave = 16'h0;
            m_val = 0; m_fmt = 0; m_to = 0;
        end else begin
            ev = tecla_valida && !m_prev;
            m_prev = tecla_valida;
            m_val = 0; m_fmt = 0; m_to = 0;
            if (!llegada || bloqueo) begin
                m_en = 0; digs.delete(); idle = 0;
            end else if (!m_en) begin
                m_en = 1;
            end else if (digs.size() > 0 && idle == TO - 1) begin
                m_to = 1; digs.delete(); idle = 0;
            end else begin
                used = 0;
                if (ev) begin
                    if (tecla_codigo <= 4'd9) begin
                        if (digs.size() < N) begin digs.push_back(tecla_codigo); used = 1; end
                    end else if (tecla_codigo == 4'hA) begin
                        digs.delete(); used = 1;
                    end else if (tecla_codigo == 4'hB) begin
                        if (digs.size() == N) begin
                            m_clave = 16'h0;
                            foreach (digs[i]) m_clave = m_clave * 16 + 16'(digs[i]);
                            m_val = 1;
                        end else m_fmt = 1;
                        digs.delete(); used = 1;
                    end
                end
                if (used) idle = 0;
                else if (digs.size() > 0) idle++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("clave", 32'(clave_ingresada), 32'(m_clave));
            check("digitos", 32'(digitos_ingresados), 32'(digs.size()));
            check("valida", 32'(clave_valida), 32'(m_val));
            check("formato", 32'(error_formato), 32'(m_fmt));
            check("timeout", 32'(error_timeout), 32'(m_to));
            if (clave_valida) n_val++;
            if (error_formato) n_fmt++;
            if (error_timeout) n_to++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [3:0] c);
        tecla_codigo = c; tecla_valida = 1'b1; tick(2);
        tecla_valida = 1'b0; tick(2);
    endtask

    int v0, f0, t0;

    initial begin
        tick(3);
        chk_en = 1'b1;
        check("rst_clave", 32'(clave_ingresada), 32'h0);
        check("rst_digitos", 32'(digitos_ingresados), 32'h0);
        reset = 1'b1;
        llegada = 1'b1;
        tick(2);

        // 1: full PIN
        v0 = n_val;
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        check("t1_digitos4", 32'(digitos_ingresados), 32'd4);
        press(4'hB);
        check("t1_clave", 32'(clave_ingresada), 32'h1234);
        check("t1_model", 32'(m_clave), 32'h1234);
        check("t1_pulsos", 32'(n_val - v0), 32'd1);
        check("t1_digitos0", 32'(digitos_ingresados), 32'd0);

        // 2: short PIN
        f0 = n_fmt;
        press(4'h5); press(4'h6); press(4'hB);
        check("t2_fmt", 32'(n_fmt - f0), 32'd1);
        check("t2_clave", 32'(clave_ingresada), 32'h1234);
        check("t2_digitos", 32'(digitos_ingresados), 32'd0);

        // 3: fifth digit ignored
        press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
        check("t3_digitos", 32'(digitos_ingresados), 32'd4);
        press(4'hB);
        check("t3_clave", 32'(clave_ingresada), 32'h9876);

        // 4: inactivity timeout
        t0 = n_to;
        press(4'h4);
        tick(TO + 2);
        check("t4_to", 32'(n_to - t0), 32'd1);
        check("t4_digitos", 32'(digitos_ingresados), 32'd0);
        press(4'h1); press(4'h1); press(4'h1); press(4'h1); press(4'hB);
        check("t4_clave", 32'(clave_ingresada), 32'h1111);

        // 5: held key, BORRAR, ignored codes
        tecla_codigo = 4'h3; tecla_valida = 1'b1; tick(50);
        tecla_valida = 1'b0; tick(2);
        check("t5_hold", 32'(digitos_ingresados), 32'd1);
        press(4'hA);
        check("t5_borrar", 32'(digitos_ingresados), 32'd0);
        t0 = n_to;
        press(4'h7); press(4'hC); press(4'hD); press(4'hE); press(4'hF);
        check("t5_ignorados", 32'(digitos_ingresados), 32'd1);
        tick(TO - 25);
        check("t5_aun_no_to", 32'(n_to - t0), 32'd0);
        tick(10);
        check("t5_to_sin_reinicio", 32'(n_to - t0), 32'd1);
        f0 = n_fmt;
        press(4'hB);
        check("t5_enter_vacio", 32'(n_fmt - f0), 32'd1);

        // 6: disable paths
        v0 = n_val; f0 = n_fmt; t0 = n_to;
        press(4'h1); press(4'h2);
        bloqueo = 1'b1; tick(2);
        check("t6_bloqueo", 32'(digitos_ingresados), 32'd0);
        bloqueo = 1'b0; tick(2);
        press(4'h5); press(4'h5); press(4'h6); press(4'h6); press(4'hB);
        check("t6_clave", 32'(clave_ingresada), 32'h5566);
        press(4'h7); press(4'h8);
        llegada = 1'b0; tick(2);
        check("t6_llegada", 32'(digitos_ingresados), 32'd0);
        check("t6_clave_kept", 32'(clave_ingresada), 32'h5566);
        llegada = 1'b1; tick(2);
        press(4'h3);
        check("t6_re", 32'(digitos_ingresados), 32'd1);
        check("t6_strobes", 32'(n_val - v0 + n_fmt - f0 + n_to - t0), 32'd1);
        @(posedge clock); #2;
        reset = 1'b0; #1;
        check("t6_rst_clave", 32'(clave_ingresada), 32'h0);
        check("t6_rst_digitos", 32'(digitos_ingresados), 32'd0);
        @(negedge clock); reset = 1'b1; tick(3);
        press(4'h4); press(4'h3); press(4'h2); press(4'h1); press(4'hB);
        check("t6_final", 32'(clave_ingresada), 32'h4321);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
